id_decode_stage: RTL and testbench

Instruction-decode pipeline stage for the SimpleCPU LoongArch32 integer core. It sits between fetch and execute and is the producer side of the ALU control interface. It accepts {pc, inst} from fetch over a valid/allowin handshake and reads the register file. It interlocks on RAW hazards against in-flight writers, then presents a registered-instruction payload to execute: a one-hot `alu_op`, both ALU operands in the ALU's operand convention, the destination, and write-enable.

---
 rtl/cpu_defs.sv | 65 ++++++
 rtl/inst_decoder.sv | 113 +++++++++++
 rtl/id_decode_stage.sv | 115 +++++++++++
 tb/tb_id_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the integer core: ALU control encoding (shared with the
// ALU), instruction opcode fields, operand-select codes and the fetch bus width.
// Also carries the RAW-hazard match helper used by the decode interlock.
package cpu_defs;

  localparam int unsigned ALU_OP_W       = 19;
  localparam int unsigned FS_TO_DS_BUS_W = 64;

  // One-hot alu_op bit positions; bits above AluLui are reserved.
  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;
  localparam int unsigned AluAnd  = 4;
  localparam int unsigned AluNor  = 5;
  localparam int unsigned AluOr   = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSll  = 8;
  localparam int unsigned AluSrl  = 9;
  localparam int unsigned AluSra  = 10;
  localparam int unsigned AluLui  = 11;

  // 3R group: inst[31:20], function in inst[19:15].
  localparam logic [11:0] Op3r      = 12'h001;
  localparam logic [4:0]  FnAdd     = 5'b00000;
  localparam logic [4:0]  FnSub     = 5'b00010;
  localparam logic [4:0]  FnSlt     = 5'b00100;
  localparam logic [4:0]  FnSltu    = 5'b00101;
  localparam logic [4:0]  FnNor     = 5'b01000;
  localparam logic [4:0]  FnAnd     = 5'b01001;
  localparam logic [4:0]  FnOr      = 5'b01010;
  localparam logic [4:0]  FnXor     = 5'b01011;
  localparam logic [4:0]  FnSll     = 5'b01110;
  localparam logic [4:0]  FnSrl     = 5'b01111;
  localparam logic [4:0]  FnSra     = 5'b10000;

  // Immediate shifts: inst[31:15].
  localparam logic [16:0] OpSlliW   = 17'h00081;
  localparam logic [16:0] OpSrliW   = 17'h00089;
  localparam logic [16:0] OpSraiW   = 17'h00091;

  // 2RI12 group: inst[31:22].
  localparam logic [9:0]  OpSlti    = 10'h008;
  localparam logic [9:0]  OpSltui   = 10'h009;
  localparam logic [9:0]  OpAddiW   = 10'h00A;
  localparam logic [9:0]  OpAndi    = 10'h00D;
  localparam logic [9:0]  OpOri     = 10'h00E;
  localparam logic [9:0]  OpXori    = 10'h00F;

  // lu12i.w: inst[31:25].
  localparam logic [6:0]  OpLu12iW  = 7'b0001010;

  typedef enum logic [1:0] {SelZero, SelRj, SelRk, SelImm} opnd_sel_e;

  // True when a used, non-zero source register is being written downstream.
  function automatic logic raw_hit(input logic [4:0] src,
                                   input logic es_we, input logic [4:0] es_dest,
                                   input logic ms_we, input logic [4:0] ms_dest,
                                   input logic ws_we, input logic [4:0] ws_dest);
    return (src != 5'd0) && ((es_we && (es_dest == src)) ||
                             (ms_we && (ms_dest == src)) ||
                             (ws_we && (ws_dest == src)));
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Purely combinational instruction decoder.
// Ports: inst (32-bit instruction) -> alu_op (one-hot), src1_sel/src2_sel
// (opnd_sel_e codes), imm (extended immediate), use_rj/use_rk (source-use
// flags for the interlock), ine (instruction not in the legal set).
module inst_decoder
  import cpu_defs::*;
(
  input  logic [31:0]         inst,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          src1_sel,
  output logic [1:0]          src2_sel,
  output logic [31:0]         imm,
  output logic                use_rj,
  output logic                use_rk,
  output logic                ine
);

  logic legal;

  always_comb begin
    alu_op   = '0;
    src1_sel = SelZero;
    src2_sel = SelZero;
    imm      = '0;
    use_rj   = 1'b0;
    use_rk   = 1'b0;
    legal    = 1'b1;

    if (inst[31:20] == Op3r) begin
      // Arithmetic/logic: adder computes src2 - src1, so rj goes to src2.
      use_rj   = 1'b1;
      use_rk   = 1'b1;
      src1_sel = SelRk;
      src2_sel = SelRj;
      unique case (inst[19:15])
        FnAdd:  alu_op[AluAdd]  = 1'b1;
        FnSub:  alu_op[AluSub]  = 1'b1;
        FnSlt:  alu_op[AluSlt]  = 1'b1;
        FnSltu: alu_op[AluSltu] = 1'b1;
        FnNor:  alu_op[AluNor]  = 1'b1;
        FnAnd:  alu_op[AluAnd]  = 1'b1;
        FnOr:   alu_op[AluOr]   = 1'b1;
        FnXor:  alu_op[AluXor]  = 1'b1;
        FnSll, FnSrl, FnSra: begin
          // Shifts take the value in src1 and the amount in src2.
          src1_sel = SelRj;
          src2_sel = SelRk;
          if (inst[19:15] == FnSll)      alu_op[AluSll] = 1'b1;
          else if (inst[19:15] == FnSrl) alu_op[AluSrl] = 1'b1;
          else                           alu_op[AluSra] = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end else if ((inst[31:15] == OpSlliW) || (inst[31:15] == OpSrliW) ||
                 (inst[31:15] == OpSraiW)) begin
      use_rj   = 1'b1;
      src1_sel = SelRj;
      src2_sel = SelImm;
      imm      = {27'd0, inst[14:10]};
      if (inst[31:15] == OpSlliW)      alu_op[AluSll] = 1'b1;
      else if (inst[31:15] == OpSrliW) alu_op[AluSrl] = 1'b1;
      else                             alu_op[AluSra] = 1'b1;
    end else if (inst[31:25] == OpLu12iW) begin
      src1_sel = SelZero;
      src2_sel = SelImm;
      imm      = {inst[24:5], 12'd0};
      alu_op[AluLui] = 1'b1;
    end else begin
      use_rj   = 1'b1;
      src1_sel = SelImm;
      src2_sel = SelRj;
      unique case (inst[31:22])
        OpSlti: begin
          alu_op[AluSlt] = 1'b1;
          imm = {{20{inst[21]}}, inst[21:10]};
        end
        OpSltui: begin
          alu_op[AluSltu] = 1'b1;
          imm = {{20{inst[21]}}, inst[21:10]};
        end
        OpAddiW: begin
          alu_op[AluAdd] = 1'b1;
          imm = {{20{inst[21]}}, inst[21:10]};
        end
        OpAndi: begin
          alu_op[AluAnd] = 1'b1;
          imm = {20'd0, inst[21:10]};
        end
        OpOri: begin
          alu_op[AluOr] = 1'b1;
          imm = {20'd0, inst[21:10]};
        end
        OpXori: begin
          alu_op[AluXor] = 1'b1;
          imm = {20'd0, inst[21:10]};
        end
        default: legal = 1'b0;
      endcase
    end

    // Illegal encodings use no sources and drive no control.
    if (!legal) begin
      alu_op   = '0;
      src1_sel = SelZero;
      src2_sel = SelZero;
      imm      = '0;
      use_rj   = 1'b0;
      use_rk   = 1'b0;
    end
    ine = !legal;
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction-decode pipeline stage.
// Ports: clk/reset (async active-high); fetch side fs_to_ds_valid,
// fs_to_ds_bus {pc,inst}, ds_allowin; execute side es_allowin, ds_to_es_valid;
// flush cancels the held instruction; rf_raddr1/2 + rf_rdata1/2 register-file
// read; es/ms/ws_we + *_dest downstream writers for the RAW interlock;
// payload ds_pc, alu_op, alu_src1, alu_src2, dest, gr_we, ine.
module id_decode_stage
  import cpu_defs::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_W-1:0] fs_to_ds_bus,
  output logic                      ds_allowin,
  input  logic                      es_allowin,
  input  logic                      flush,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [31:0]               rf_rdata1,
  input  logic [31:0]               rf_rdata2,
  input  logic                      es_we,
  input  logic                      ms_we,
  input  logic                      ws_we,
  input  logic [4:0]                es_dest,
  input  logic [4:0]                ms_dest,
  input  logic [4:0]                ws_dest,
  output logic                      ds_to_es_valid,
  output logic [31:0]               ds_pc,
  output logic [ALU_OP_W-1:0]       alu_op,
  output logic [31:0]               alu_src1,
  output logic [31:0]               alu_src2,
  output logic [4:0]                dest,
  output logic                      gr_we,
  output logic                      ine
);

  logic                ds_valid;
  logic [31:0]         ds_inst;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic [1:0]          dec_src1_sel;
  logic [1:0]          dec_src2_sel;
  logic [31:0]         dec_imm;
  logic                dec_use_rj;
  logic                dec_use_rk;
  logic                dec_ine;
  logic                stall;
  logic                ds_ready_go;

  inst_decoder u_inst_decoder (
    .inst     (ds_inst),
    .alu_op   (dec_alu_op),
    .src1_sel (dec_src1_sel),
    .src2_sel (dec_src2_sel),
    .imm      (dec_imm),
    .use_rj   (dec_use_rj),
    .use_rk   (dec_use_rk),
    .ine      (dec_ine)
  );

  assign rf_raddr1 = ds_inst[9:5];
  assign rf_raddr2 = ds_inst[14:10];
  assign dest      = ds_inst[4:0];

  always_comb begin
    stall = ds_valid &&
            ((dec_use_rj && raw_hit(rf_raddr1, es_we, es_dest, ms_we, ms_dest, ws_we, ws_dest)) ||
             (dec_use_rk && raw_hit(rf_raddr2, es_we, es_dest, ms_we, ms_dest, ws_we, ws_dest)));
    ds_ready_go    = !stall;
    ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    ds_to_es_valid = ds_valid && ds_ready_go && !flush;
  end

  // Flush wins over a simultaneous load; the bus only latches a valid payload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_pc    <= 32'd0;
      ds_inst  <= 32'd0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_pc   <= fs_to_ds_bus[63:32];
        ds_inst <= fs_to_ds_bus[31:0];
      end
    end
  end

  always_comb begin
    alu_op   = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    gr_we    = 1'b0;
    ine      = 1'b0;
    if (ds_valid) begin
      alu_op = dec_alu_op;
      gr_we  = !dec_ine && (dest != 5'd0);
      ine    = dec_ine;
      unique case (dec_src1_sel)
        SelRj:   alu_src1 = rf_rdata1;
        SelRk:   alu_src1 = rf_rdata2;
        SelImm:  alu_src1 = dec_imm;
        default: alu_src1 = 32'd0;
      endcase
      unique case (dec_src2_sel)
        SelRj:   alu_src2 = rf_rdata1;
        SelRk:   alu_src2 = rf_rdata2;
        SelImm:  alu_src2 = dec_imm;
        default: alu_src2 = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: stimulus pushes expected payloads,
// a negedge monitor pops and compares on every transfer to execute.
module tb_id_decode_stage;
  import cpu_defs::*;

  localparam logic [31:0] InstAdd   = 32'h0010_0823; // add.w r3,r1,r2
  localparam logic [31:0] InstAddR0 = 32'h0010_0820; // add.w r0,r1,r2
  localparam logic [31:0] InstSll   = 32'h0017_2928; // sll.w r8,r9,r10
  localparam logic [31:0] InstAndi  = 32'h037F_FD8B; // andi r11,r12,0xfff
  localparam logic [31:0] InstAddi  = 32'h02BF_FC24; // addi.w r4,r1,-1
  localparam logic [31:0] InstLui   = 32'h1424_68A5; // lu12i.w r5,0x12345
  localparam logic [31:0] InstSrai  = 32'h0048_FCE6; // srai.w r6,r7,31
  localparam logic [31:0] InstBad   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fs_to_ds_valid, ds_allowin, es_allowin, flush;
  logic [63:0] fs_to_ds_bus;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        es_we, ms_we, ws_we;
  logic [4:0]  es_dest, ms_dest, ws_dest;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, alu_src1, alu_src2;
  logic [18:0] alu_op;
  logic [4:0]  dest;
  logic        gr_we, ine;

  id_decode_stage dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .flush          (flush),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .es_we          (es_we),
    .ms_we          (ms_we),
    .ws_we          (ws_we),
    .es_dest        (es_dest),
    .ms_dest        (ms_dest),
    .ws_dest        (ws_dest),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_pc          (ds_pc),
    .alu_op         (alu_op),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .dest           (dest),
    .gr_we          (gr_we),
    .ine            (ine)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [18:0] op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  d;
    logic        we;
    logic        ine;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          c0;
  logic [31:0] regs [32];

  always_comb begin
    rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
    rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [18:0] op, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [4:0] d, input logic we,
                      input logic inx);
    exp_t x;
    x.pc = pc; x.op = op; x.s1 = s1; x.s2 = s2; x.d = d; x.we = we; x.ine = inx;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one payload and return in the cycle after it was accepted.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    int n = 0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {pc, inst};
    while (!ds_allowin && n < 50) begin
      step(1);
      n++;
    end
    check("send_accept", 32'(n < 50), 32'd1);
    step(1);
    fs_to_ds_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && ds_to_es_valid && es_allowin) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: transfer of pc 0x%08h, none expected", ds_pc);
      end else begin
        mon_e = sb.pop_front();
        check("xfer_pc", ds_pc, mon_e.pc);
        check("xfer_alu_op", 32'(alu_op), 32'(mon_e.op));
        check("xfer_src1", alu_src1, mon_e.s1);
        check("xfer_src2", alu_src2, mon_e.s2);
        check("xfer_dest", 32'(dest), 32'(mon_e.d));
        check("xfer_gr_we", 32'(gr_we), 32'(mon_e.we));
        check("xfer_ine", 32'(ine), 32'(mon_e.ine));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b1; flush = 1'b0;
    es_we = 1'b0; ms_we = 1'b0; ws_we = 1'b0; es_dest = '0; ms_dest = '0; ws_dest = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    #1 reset = 1'b1;
    #1;
    check("rst_allowin", 32'(ds_allowin), 32'd1);
    check("rst_valid", 32'(ds_to_es_valid), 32'd0);
    check("rst_pc", ds_pc, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_gr_we", 32'(gr_we), 32'd0);
    check("rst_ine", 32'(ine), 32'd0);
    check("rst_src2", alu_src2, 32'd0);
    step(2);
    reset = 1'b0;

    regs[1] = 32'd5; regs[2] = 32'd7; regs[7] = 32'h8000_0000;
    regs[9] = 32'h11; regs[10] = 32'h24; regs[12] = 32'hF0F0_F0F0;

    push(32'h100, 19'h00001, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0);
    send(32'h100, InstAdd);
    push(32'h104, 19'h00001, 32'd7, 32'd5, 5'd0, 1'b0, 1'b0);
    send(32'h104, InstAddR0);
    push(32'h108, 19'h00100, 32'h11, 32'h24, 5'd8, 1'b1, 1'b0);
    send(32'h108, InstSll);
    push(32'h10C, 19'h00010, 32'h0000_0FFF, 32'hF0F0_F0F0, 5'd11, 1'b1, 1'b0);
    send(32'h10C, InstAndi);
    step(2);

    // Back-to-back: three accepts in three cycles.
    regs[1] = 32'h10;
    c0 = cyc;
    push(32'h200, 19'h00001, 32'hFFFF_FFFF, 32'h10, 5'd4, 1'b1, 1'b0);
    send(32'h200, InstAddi);
    push(32'h204, 19'h00800, 32'd0, 32'h1234_5000, 5'd5, 1'b1, 1'b0);
    send(32'h204, InstLui);
    push(32'h208, 19'h00400, 32'h8000_0000, 32'd31, 5'd6, 1'b1, 1'b0);
    send(32'h208, InstSrai);
    check("b2b_cycles", 32'(cyc - c0), 32'd3);
    step(2);
    regs[1] = 32'd5;

    // rj hazard against execute.
    es_we = 1'b1; es_dest = 5'd1;
    push(32'h300, 19'h00001, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0);
    send(32'h300, InstAdd);
    @(negedge clk);
    check("stall_valid", 32'(ds_to_es_valid), 32'd0);
    check("stall_allowin", 32'(ds_allowin), 32'd0);
    check("stall_alu_op", 32'(alu_op), 32'h1);
    repeat (2) begin
      step(1);
      @(negedge clk);
      check("stall_hold_valid", 32'(ds_to_es_valid), 32'd0);
      check("stall_hold_pc", ds_pc, 32'h300);
    end
    step(1);
    es_we = 1'b0;
    @(negedge clk);
    check("stall_release", 32'(ds_to_es_valid), 32'd1);
    step(1);

    // rk hazard against writeback.
    ws_we = 1'b1; ws_dest = 5'd2;
    push(32'h304, 19'h00001, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0);
    send(32'h304, InstAdd);
    @(negedge clk);
    check("rk_stall", 32'(ds_to_es_valid), 32'd0);
    step(1);
    ws_we = 1'b0; ws_dest = 5'd0;
    @(negedge clk);
    check("rk_release", 32'(ds_to_es_valid), 32'd1);
    step(1);

    // Writer to r0 never interlocks; lu12i.w does not read rj.
    es_we = 1'b1; es_dest = 5'd0;
    push(32'h308, 19'h00001, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0);
    send(32'h308, InstAdd);
    @(negedge clk);
    check("r0_no_stall", 32'(ds_to_es_valid), 32'd1);
    step(1);
    es_dest = 5'd5;
    push(32'h30C, 19'h00800, 32'd0, 32'h1234_5000, 5'd5, 1'b1, 1'b0);
    send(32'h30C, InstLui);
    @(negedge clk);
    check("lui_no_stall", 32'(ds_to_es_valid), 32'd1);
    step(1);
    es_we = 1'b0; es_dest = 5'd0;

    // Illegal instruction held under execute backpressure, fetch blocked.
    es_allowin = 1'b0;
    push(32'h400, 19'h0, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1);
    send(32'h400, InstBad);
    push(32'h404, 19'h00001, 32'd7, 32'd5, 5'd3, 1'b1, 1'b0);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {32'h404, InstAdd};
    repeat (3) begin
      @(negedge clk);
      check("bp_allowin", 32'(ds_allowin), 32'd0);
      check("bp_valid", 32'(ds_to_es_valid), 32'd1);
      check("bp_pc", ds_pc, 32'h400);
      check("bp_ine", 32'(ine), 32'd1);
      step(1);
    end
    es_allowin = 1'b1;
    step(1);
    fs_to_ds_valid = 1'b0;
    step(1);

    // Flush while stalled.
    es_we = 1'b1; es_dest = 5'd1;
    send(32'h500, InstAdd);
    @(negedge clk);
    check("fl_stalled", 32'(ds_to_es_valid), 32'd0);
    step(1);
    flush = 1'b1;
    @(negedge clk);
    check("fl_cycle_valid", 32'(ds_to_es_valid), 32'd0);
    step(1);
    flush = 1'b0;
    @(negedge clk);
    check("fl_allowin", 32'(ds_allowin), 32'd1);
    check("fl_alu_op", 32'(alu_op), 32'd0);
    step(1);
    es_we = 1'b0; es_dest = 5'd0;
    @(negedge clk);
    check("fl_no_revive", 32'(ds_to_es_valid), 32'd0);
    step(1);

    // Flush masks ds_to_es_valid in the same cycle.
    send(32'h504, InstAdd);
    flush = 1'b1;
    @(negedge clk);
    check("fl_same_cycle", 32'(ds_to_es_valid), 32'd0);
    step(1);
    flush = 1'b0;

    // Asynchronous reset between edges.
    send(32'h600, InstAdd);
    #1;
    check("pre_rst_valid", 32'(ds_to_es_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("arst_valid", 32'(ds_to_es_valid), 32'd0);
    check("arst_pc", ds_pc, 32'd0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_gr_we", 32'(gr_we), 32'd0);
    check("arst_src2", alu_src2, 32'd0);
    check("arst_allowin", 32'(ds_allowin), 32'd1);
    step(1);
    reset = 1'b0;
    step(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
